// File: rtl/inst_fetch_pkg.sv
// Shared pipeline constants: inst_type codes, NOP word and fetch FSM encoding.
package inst_fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned IMME_W = 8;

  localparam logic [TYPE_W-1:0] INST_TYPE_JAL  = 3'b111;
  localparam logic [TYPE_W-1:0] INST_TYPE_JALR = 3'b101;
  localparam logic [TYPE_W-1:0] INST_TYPE_BCC  = 3'b100;

  localparam logic [INST_W-1:0] PKG_NOP_INST = 32'h0000_0013;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_HOLD = 2'd2;
  localparam logic [ST_W-1:0] ST_HALT = 2'd3;

endpackage

// File: rtl/inst_fetch_predecode.sv
// Combinational pre-decode of the fields the next-PC logic consumes.
module inst_predecode
  import inst_fetch_pkg::*;
(
  input  logic [31:0]       inst_i,
  output logic [2:0]        inst_type_o,
  output logic [1:0]        funct2_o,
  output logic signed [7:0] imme_o
);

  logic unused_bits;

  assign inst_type_o = {inst_i[6], inst_i[3:2]};
  assign funct2_o    = {inst_i[14], inst_i[12]};

  // Word offset only exists for branches and JAL; everything else reads as 0.
  always_comb begin
    imme_o = '0;
    case (inst_type_o)
      INST_TYPE_BCC: imme_o = {inst_i[29:25], inst_i[11:9]};
      INST_TYPE_JAL: imme_o = inst_i[29:22];
      default:       imme_o = '0;
    endcase
  end

  assign unused_bits = ^{inst_i[31:30], inst_i[21:15], inst_i[13], inst_i[8:7],
                         inst_i[5:4], inst_i[1:0]};

endmodule

// File: rtl/inst_fetch.sv
// IF front end: one outstanding imem read, bypass of returning data to ID,
// hold register across ID stalls, and halt on fetch address all-ones.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] NOP_INST = PKG_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              nop,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  output logic [31:0]       inst,
  output logic [2:0]        inst_type,
  output logic [1:0]        funct2,
  output logic signed [7:0] imme,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] HALT_PC = '1;

  logic [ST_W-1:0] state_q, state_d;
  logic [31:0]     hold_q, hold_d;
  logic            req_c;
  logic            valid_c;
  logic [31:0]     inst_c;
  logic            halt_pc_c;

  assign halt_pc_c = (pc_next == HALT_PC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, request and ID-presentation logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    req_c   = 1'b0;
    valid_c = 1'b0;
    inst_c  = NOP_INST;
    case (state_q)
      ST_IDLE: begin
        if (halt_pc_c) begin
          state_d = ST_HALT;
        end else begin
          req_c   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          valid_c = 1'b1;
          inst_c  = imem_rdata;
          if (nop) begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end else if (halt_pc_c) begin
            state_d = ST_HALT;
          end else begin
            req_c = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        valid_c = 1'b1;
        inst_c  = hold_q;
        if (!nop) begin
          if (halt_pc_c) begin
            state_d = ST_HALT;
          end else begin
            req_c   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // IDLE requests combinationally, so mask while reset is still asserted.
  assign imem_req  = req_c & rst;
  assign imem_addr = imem_req ? pc_next : '0;
  assign id_valid  = valid_c;
  assign inst      = inst_c;
  assign halted    = (state_q == ST_HALT);

  inst_predecode u_predecode (
    .inst_i      (inst_c),
    .inst_type_o (inst_type),
    .funct2_o    (funct2),
    .imme_o      (imme)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed-vector bench for inst_fetch with hand-computed expectations.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'hFE00_0CE3; // beq x0,x0,-8
  localparam logic [31:0] W1  = 32'h0100_00EF; // jal x1,+16
  localparam logic [31:0] W2  = 32'h00A0_0093; // addi
  localparam logic [31:0] W3  = 32'h0000_9067; // jalr-class, funct2 01
  localparam logic [31:0] W4  = 32'h0040_006F; // jal x0,+4
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        pc_next;
  logic              nop;
  logic              imem_req;
  logic [7:0]        imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic [31:0]       inst;
  logic [2:0]        inst_type;
  logic [1:0]        funct2;
  logic signed [7:0] imme;
  logic              halted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(8), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_next     (pc_next),
    .nop         (nop),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .inst        (inst),
    .inst_type   (inst_type),
    .funct2      (funct2),
    .imme        (imme),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_io(input string tag, input logic req, input logic [7:0] addr,
                        input logic vld, input logic [31:0] ins, input logic hlt);
    chk({tag, ".req"},    {31'd0, imem_req},  {31'd0, req});
    chk({tag, ".addr"},   {24'd0, imem_addr}, {24'd0, addr});
    chk({tag, ".valid"},  {31'd0, id_valid},  {31'd0, vld});
    chk({tag, ".inst"},   inst,               ins);
    chk({tag, ".halted"}, {31'd0, halted},    {31'd0, hlt});
  endtask

  task automatic exp_dec(input string tag, input logic [2:0] ty, input logic [1:0] f2,
                         input logic [7:0] im);
    chk({tag, ".type"}, {29'd0, inst_type}, {29'd0, ty});
    chk({tag, ".f2"},   {30'd0, funct2},    {30'd0, f2});
    chk({tag, ".imme"}, {24'd0, imme},      {24'd0, im});
  endtask

  // Inputs change 1ns after the rising edge; outputs sampled 1ns later.
  task automatic drive(input logic r, input logic [7:0] pc, input logic n,
                       input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst = r; pc_next = pc; nop = n; imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  initial begin
    rst = 1'b0; pc_next = 8'h00; nop = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);
    #3;
    exp_io("reset", 1'b0, 8'h00, 1'b0, NOP, 1'b0);
    exp_dec("reset", 3'b000, 2'b00, 8'h00);

    // 1-cycle memory, back-to-back fetch
    drive(1'b1, 8'h00, 1'b0, 1'b0, '0);
    exp_io("c1", 1'b1, 8'h00, 1'b0, NOP, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b1, W0);
    exp_io("c2", 1'b1, 8'h01, 1'b1, W0, 1'b0);
    exp_dec("beq", 3'b100, 2'b00, 8'hFE);
    drive(1'b1, 8'h02, 1'b0, 1'b1, W1);
    exp_io("c3", 1'b1, 8'h02, 1'b1, W1, 1'b0);
    exp_dec("jal16", 3'b111, 2'b00, 8'h04);

    // 3-cycle memory: valid pattern 0,0,1, no request while pending
    drive(1'b1, 8'h03, 1'b0, 1'b0, BAD);
    exp_io("m3a", 1'b0, 8'h00, 1'b0, NOP, 1'b0);
    exp_dec("bubble", 3'b000, 2'b00, 8'h00);
    drive(1'b1, 8'h03, 1'b0, 1'b0, BAD);
    exp_io("m3b", 1'b0, 8'h00, 1'b0, NOP, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b1, W2);
    exp_io("m3c", 1'b1, 8'h03, 1'b1, W2, 1'b0);
    exp_dec("addi", 3'b000, 2'b00, 8'h00);
    drive(1'b1, 8'h04, 1'b0, 1'b0, BAD);
    exp_io("m3d", 1'b0, 8'h00, 1'b0, NOP, 1'b0);
    drive(1'b1, 8'h04, 1'b0, 1'b0, BAD);
    exp_io("m3e", 1'b0, 8'h00, 1'b0, NOP, 1'b0);

    // response coincident with nop: capture, hold for 2 cycles, request on release
    drive(1'b1, 8'h04, 1'b1, 1'b1, W3);
    exp_io("hold0", 1'b0, 8'h00, 1'b1, W3, 1'b0);
    exp_dec("jalr", 3'b101, 2'b01, 8'h00);
    drive(1'b1, 8'h04, 1'b1, 1'b0, BAD);
    exp_io("hold1", 1'b0, 8'h00, 1'b1, W3, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0, BAD);
    exp_io("hold2", 1'b1, 8'h05, 1'b1, W3, 1'b0);

    // consume with pc_next = ff: word delivered, no request, then halt
    drive(1'b1, 8'hff, 1'b0, 1'b1, W4);
    exp_io("ff", 1'b0, 8'h00, 1'b1, W4, 1'b0);
    exp_dec("jal4", 3'b111, 2'b00, 8'h01);
    drive(1'b1, 8'h06, 1'b0, 1'b1, W0);
    exp_io("halt0", 1'b0, 8'h00, 1'b0, NOP, 1'b1);
    drive(1'b1, 8'h06, 1'b0, 1'b0, W0);
    exp_io("halt1", 1'b0, 8'h00, 1'b0, NOP, 1'b1);

    // reset leaves HALT
    rst = 1'b0;
    #1;
    exp_io("rst_halt", 1'b0, 8'h00, 1'b0, NOP, 1'b0);

    // reset while a request is outstanding, stale response in IDLE
    drive(1'b1, 8'h20, 1'b0, 1'b0, '0);
    exp_io("r1", 1'b1, 8'h20, 1'b0, NOP, 1'b0);
    drive(1'b1, 8'h21, 1'b0, 1'b0, '0);
    exp_io("r2", 1'b0, 8'h00, 1'b0, NOP, 1'b0);
    rst = 1'b0;
    #1;
    exp_io("rst_mid", 1'b0, 8'h00, 1'b0, NOP, 1'b0);
    drive(1'b0, 8'h30, 1'b0, 1'b1, BAD);
    exp_io("in_rst", 1'b0, 8'h00, 1'b0, NOP, 1'b0);
    drive(1'b1, 8'h30, 1'b0, 1'b1, BAD);
    exp_io("stale", 1'b1, 8'h30, 1'b0, NOP, 1'b0);
    drive(1'b1, 8'h31, 1'b0, 1'b1, W1);
    exp_io("fresh", 1'b1, 8'h31, 1'b1, W1, 1'b0);

    // IDLE with pc_next = ff goes straight to HALT without a request
    rst = 1'b0;
    #1;
    drive(1'b1, 8'hff, 1'b0, 1'b0, '0);
    exp_io("idle_ff", 1'b0, 8'h00, 1'b0, NOP, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0, '0);
    exp_io("idle_ff_h", 1'b0, 8'h00, 1'b0, NOP, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
